// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 4-point radix-4 FFT/IFFT blocks.
package fft_pkg;

    localparam int FFT4_N     = 4;
    localparam int FFT4_IDX_W = 2;

    // Slot s of an incoming frame carries frequency bin FFT4_SLOT_BIN[s] (bit-reversed order).
    localparam int FFT4_SLOT_BIN [FFT4_N] = '{0, 2, 1, 3};

    // Output width of the 4-point butterfly: two adder stages of growth.
    function automatic int fft4_out_width(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/ifft4_butterfly_core.sv
// Combinational 4-point inverse radix-4 butterfly. Inputs are frequency bins in
// natural order (X0..X3), outputs are time samples x0..x3, optionally divided by 4.
module ifft4_butterfly_core
    import fft_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter bit  SCALE      = 1'b1,
    localparam int OUT_W      = fft4_out_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] x_re_i [FFT4_N],
    input  logic [DATA_WIDTH-1:0] x_im_i [FFT4_N],
    output logic [OUT_W-1:0]      y_re_o [FFT4_N],
    output logic [OUT_W-1:0]      y_im_o [FFT4_N]
);

    localparam int SUM_W = DATA_WIDTH + 1;

    function automatic logic [SUM_W-1:0] ext1(input logic [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-1], v};
    endfunction

    function automatic logic [OUT_W-1:0] ext2(input logic [SUM_W-1:0] v);
        return {v[SUM_W-1], v};
    endfunction

    // Arithmetic shift by 2 (floor), no rounding; result already sits in OUT_W bits.
    function automatic logic [OUT_W-1:0] apply_scale(input logic [OUT_W-1:0] v);
        if (SCALE) begin
            return {{2{v[OUT_W-1]}}, v[OUT_W-1:2]};
        end
        return v;
    endfunction

    logic [SUM_W-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
    logic [OUT_W-1:0] r_re [FFT4_N];
    logic [OUT_W-1:0] r_im [FFT4_N];

    // First stage: even/odd sums and differences, one bit of growth.
    assign a_re = ext1(x_re_i[0]) + ext1(x_re_i[2]);
    assign a_im = ext1(x_im_i[0]) + ext1(x_im_i[2]);
    assign b_re = ext1(x_re_i[1]) + ext1(x_re_i[3]);
    assign b_im = ext1(x_im_i[1]) + ext1(x_im_i[3]);
    assign c_re = ext1(x_re_i[0]) - ext1(x_re_i[2]);
    assign c_im = ext1(x_im_i[0]) - ext1(x_im_i[2]);
    assign d_re = ext1(x_re_i[1]) - ext1(x_re_i[3]);
    assign d_im = ext1(x_im_i[1]) - ext1(x_im_i[3]);

    // Second stage: the inverse twiddle is +j, so x1 = C + jD and x3 = C - jD.
    assign r_re[0] = ext2(a_re) + ext2(b_re);
    assign r_im[0] = ext2(a_im) + ext2(b_im);
    assign r_re[2] = ext2(a_re) - ext2(b_re);
    assign r_im[2] = ext2(a_im) - ext2(b_im);
    assign r_re[1] = ext2(c_re) - ext2(d_im);
    assign r_im[1] = ext2(c_im) + ext2(d_re);
    assign r_re[3] = ext2(c_re) + ext2(d_im);
    assign r_im[3] = ext2(c_im) - ext2(d_re);

    for (genvar n = 0; n < FFT4_N; n++) begin : g_scale
        assign y_re_o[n] = apply_scale(r_re[n]);
        assign y_im_o[n] = apply_scale(r_im[n]);
    end

endmodule

// File: rtl/ifft4_stream_radix4.sv
// Streaming 4-point inverse DFT: one-frame input buffer, registered butterfly into a
// one-frame output buffer, so a frame can be collected while the previous one drains.
module ifft4_stream_radix4
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter bit SCALE      = 1'b1
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic                    s_sof_i,
    input  logic [DATA_WIDTH-1:0]   s_real_i,
    input  logic [DATA_WIDTH-1:0]   s_imag_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [DATA_WIDTH+1:0]   m_real_o,
    output logic [DATA_WIDTH+1:0]   m_imag_o,
    output logic [FFT4_IDX_W-1:0]   m_idx_o,
    output logic                    m_last_o,
    output logic                    err_o
);

    localparam int                    OUT_W    = fft4_out_width(DATA_WIDTH);
    localparam logic [FFT4_IDX_W-1:0] LAST_IDX = FFT4_IDX_W'(FFT4_N - 1);
    localparam logic [FFT4_IDX_W-1:0] IDX_ONE  = FFT4_IDX_W'(1);

    // Input side state
    logic [FFT4_IDX_W-1:0] cnt_q, cnt_d;
    logic                  in_full_q, in_full_d;
    logic [DATA_WIDTH-1:0] in_re_q [FFT4_N];
    logic [DATA_WIDTH-1:0] in_im_q [FFT4_N];
    logic [DATA_WIDTH-1:0] in_re_d [FFT4_N];
    logic [DATA_WIDTH-1:0] in_im_d [FFT4_N];
    logic                  err_q, err_d;

    // Output side state
    logic                  out_busy_q, out_busy_d;
    logic [FFT4_IDX_W-1:0] out_idx_q, out_idx_d;
    logic [OUT_W-1:0]      out_re_q [FFT4_N];
    logic [OUT_W-1:0]      out_im_q [FFT4_N];
    logic [OUT_W-1:0]      out_re_d [FFT4_N];
    logic [OUT_W-1:0]      out_im_d [FFT4_N];

    // Butterfly interface
    logic [DATA_WIDTH-1:0] bin_re [FFT4_N];
    logic [DATA_WIDTH-1:0] bin_im [FFT4_N];
    logic [OUT_W-1:0]      y_re   [FFT4_N];
    logic [OUT_W-1:0]      y_im   [FFT4_N];

    logic in_fire, out_take, drain_done, xfer;

    assign out_take   = out_busy_q & m_ready_i;
    assign drain_done = out_take & (out_idx_q == LAST_IDX);
    assign xfer       = in_full_q & (~out_busy_q | drain_done);
    assign s_ready_o  = ~in_full_q | xfer;
    assign in_fire    = s_valid_i & s_ready_o;

    assign m_valid_o  = out_busy_q;
    assign m_idx_o    = out_idx_q;
    assign m_last_o   = (out_idx_q == LAST_IDX);
    assign m_real_o   = out_re_q[out_idx_q];
    assign m_imag_o   = out_im_q[out_idx_q];
    assign err_o      = err_q;

    // Undo the bit-reversed arrival order so the core sees bins in natural order.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        for (int k = 0; k < FFT4_N; k++) begin
            bin_re[k] = '0;
            bin_im[k] = '0;
        end
        for (int s = 0; s < FFT4_N; s++) begin
            bin_re[FFT4_SLOT_BIN[s]] = in_re_q[s];
            bin_im[FFT4_SLOT_BIN[s]] = in_im_q[s];
        end
    end

    ifft4_butterfly_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .SCALE      (SCALE)
    ) u_core (
        .x_re_i (bin_re),
        .x_im_i (bin_im),
        .y_re_o (y_re),
        .y_im_o (y_im)
    );

    // Input buffer: slot write, resync on a mid-frame sof, frame-complete flag.
    always_comb begin
        cnt_d     = cnt_q;
        in_full_d = in_full_q;
        in_re_d   = in_re_q;
        in_im_d   = in_im_q;
        err_d     = 1'b0;
        if (xfer) begin
            in_full_d = 1'b0;
        end
        if (in_fire) begin
            if (s_sof_i && (cnt_q != '0)) begin
                err_d      = 1'b1;
                in_re_d[0] = s_real_i;
                in_im_d[0] = s_imag_i;
                cnt_d      = IDX_ONE;
            end else begin
                in_re_d[cnt_q] = s_real_i;
                in_im_d[cnt_q] = s_imag_i;
                cnt_d          = cnt_q + IDX_ONE;
                if (cnt_q == LAST_IDX) begin
                    in_full_d = 1'b1;
                end
            end
        end
    end

    // Output buffer: load on xfer (takes priority over the final drain beat), else step the index.
    always_comb begin
        out_busy_d = out_busy_q;
        out_idx_d  = out_idx_q;
        out_re_d   = out_re_q;
        out_im_d   = out_im_q;
        if (xfer) begin
            out_busy_d = 1'b1;
            out_idx_d  = '0;
            out_re_d   = y_re;
            out_im_d   = y_im;
        end else if (out_take) begin
            out_idx_d = out_idx_q + IDX_ONE;
            if (out_idx_q == LAST_IDX) begin
                out_busy_d = 1'b0;
            end
        end
    end

    // State registers; reset drops both buffers at once.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            cnt_q      <= '0;
            in_full_q  <= 1'b0;
            err_q      <= 1'b0;
            out_busy_q <= 1'b0;
            out_idx_q  <= '0;
            // NOTE: the buffers are reset too, so the data outputs read zero straight out of reset.
            for (int i = 0; i < FFT4_N; i++) begin
                in_re_q[i]  <= '0;
                in_im_q[i]  <= '0;
                out_re_q[i] <= '0;
                out_im_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            cnt_q      <= cnt_d;
            in_full_q  <= in_full_d;
            err_q      <= err_d;
            out_busy_q <= out_busy_d;
            out_idx_q  <= out_idx_d;
            in_re_q    <= in_re_d;
            in_im_q    <= in_im_d;
            out_re_q   <= out_re_d;
            out_im_q   <= out_im_d;
        end
    end

endmodule
